// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_pkg                                                          |
// | Shared state encoding and frame constants for the PS/2 receiver. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam logic       PS2_START_BIT  = 1'b0;
  localparam logic       PS2_STOP_BIT   = 1'b1;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/ps2_input_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_input_filter                                                 |
// | Two-flop synchroniser plus glitch filter for one PS/2 pin.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level
);

  localparam int c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic                r_s1;
  logic                r_s2;
  logic                r_level;
  logic [c_cnt_w-1:0]  r_cnt;

  // The bus idles high, so every stage is preset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_w'(FILTER_LEN - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_frame_rx                                                     |
// | PS/2 frame receiver: pin conditioning, deframing, parity check.  |
// | Optional macro PS2_BREAK_TRACK_EN folds F0 into is_break.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 4160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_to_w = $clog2(TIMEOUT_CYCLES);

  ps2_rx_state_t       r_state;
  ps2_rx_state_t       w_state_nxt;
  logic                w_clk_f;
  logic                w_data_f;
  logic                r_clk_prev;
  logic                w_fall;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_sr;
  logic                r_par;
  logic [c_to_w-1:0]   r_idle_cnt;
  logic                w_timeout;
  logic                w_shift;
  logic                w_store_par;
  logic                w_accept;
  logic                w_par_err;
  logic                w_frm_err;
  logic                w_emit;
  logic                w_emit_brk;
  logic [7:0]          r_scan_code;
  logic                r_code_valid;
  logic                r_is_break;
  logic                r_parity_err;
  logic                r_frame_err;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst     (reset),
    .i_pin   (ps2_clk),
    .o_level (w_clk_f)
  );

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .rst     (reset),
    .i_pin   (ps2_data),
    .o_level (w_data_f)
  );

  assign w_fall = r_clk_prev & ~w_clk_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_store_par = 1'b0;
    w_accept    = 1'b0;
    w_par_err   = 1'b0;
    w_frm_err   = 1'b0;
    // Fires as the counter would reach TIMEOUT_CYCLES-1, so the strobe
    // lands exactly TIMEOUT_CYCLES cycles after the last fall.
    w_timeout   = (r_state != IDLE) && !w_fall &&
                  (r_idle_cnt == c_to_w'(TIMEOUT_CYCLES - 2));
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_frm_err   = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (w_data_f == PS2_START_BIT) w_state_nxt = DATA;
          else                           w_frm_err   = 1'b1;
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_store_par = 1'b1;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (w_data_f != PS2_STOP_BIT) w_frm_err = 1'b1;
          else if (^{r_sr, r_par})      w_accept  = 1'b1;
          else                          w_par_err = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_prev <= 1'b1;
      r_bitcnt   <= '0;
      r_sr       <= '0;
      r_par      <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_clk_prev <= w_clk_f;
      if (w_shift)              r_bitcnt <= r_bitcnt + 1'b1;
      else if (r_state == IDLE) r_bitcnt <= '0;
      if (w_shift)     r_sr  <= {w_data_f, r_sr[7:1]};
      if (w_store_par) r_par <= w_data_f;
      if (r_state == IDLE || w_fall || w_timeout) r_idle_cnt <= '0;
      else                                        r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

`ifdef PS2_BREAK_TRACK_EN
  logic r_break_pend;

  assign w_emit     = w_accept && (r_sr != PS2_BREAK_CODE);
  assign w_emit_brk = w_emit && r_break_pend;

  // F0 arms the flag (and keeps it armed on F0 F0); any other accept consumes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_break_pend <= 1'b0;
    else if (w_par_err || w_frm_err) r_break_pend <= 1'b0;
    else if (w_accept)               r_break_pend <= (r_sr == PS2_BREAK_CODE);
  end
`else
  assign w_emit     = w_accept;
  assign w_emit_brk = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_code  <= '0;
      r_code_valid <= 1'b0;
      r_is_break   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_emit) r_scan_code <= r_sr;
      r_code_valid <= w_emit;
      r_is_break   <= w_emit_brk;
      r_parity_err <= w_par_err;
      r_frame_err  <= w_frm_err;
    end
  end

  assign scan_code  = r_scan_code;
  assign code_valid = r_code_valid;
  assign is_break   = r_is_break;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ps2_frame_rx                                                  |
// | Scoreboard bench: stimulus queues expected strobes, monitor pops. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 4160;
  localparam int HALF_BIT       = 83;

  localparam logic [2:0] S_CODE = 3'b100;
  localparam logic [2:0] S_PAR  = 3'b010;
  localparam logic [2:0] S_FRM  = 3'b001;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       is_break;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [2:0] strb;
    logic [7:0] code;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .is_break   (is_break),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #240 clk = ~clk;

  initial begin
    #60ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    logic [2:0] act;
    exp_t       e;
    #1;
    act = {code_valid, parity_err, frame_err};
    if (!reset && act != 3'b000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_strobe: got strobes=%b code=%h brk=%b, required none", act, scan_code, is_break);
      end else begin
        e = exp_q.pop_front();
        if (act != e.strb || scan_code != e.code || is_break != e.brk) begin
          n_errors++;
          $display("FAIL strobe: got strobes=%b code=%h brk=%b, required strobes=%b code=%h brk=%b",
                   act, scan_code, is_break, e.strb, e.code, e.brk);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [2:0] strb, input logic [7:0] code, input logic brk);
    exp_q.push_back('{strb: strb, code: code, brk: brk});
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (200) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int          n;
    logic        got;

    repeat (5) @(negedge clk);
    chk("reset_scan_code",  32'(scan_code),  32'h00);
    chk("reset_code_valid", 32'(code_valid), 32'h0);
    chk("reset_is_break",   32'(is_break),   32'h0);
    chk("reset_parity_err", 32'(parity_err), 32'h0);
    chk("reset_frame_err",  32'(frame_err),  32'h0);
    chk("reset_busy",       32'(busy),       32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Good 0x1C: three ones, so odd parity bit is 0.
    push_exp(S_CODE, 8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    push_exp(S_PAR, 8'h1C, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);

    push_exp(S_FRM, 8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    push_exp(S_CODE, 8'h32, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1);

    // A fall with data high while idle is a bad start bit.
    push_exp(S_FRM, 8'h32, 1'b0);
    ps2_bit(1'b1);
    repeat (50) @(negedge clk);
    chk("bad_start_busy", 32'(busy), 32'h0);

    // Start plus five data bits, then the clock stops.
    bits = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
    push_exp(S_FRM, 8'h32, 1'b0);
    @(negedge clk);
    ps2_data = bits[5];
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < TIMEOUT_CYCLES + 50 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == HALF_BIT) ps2_clk = 1'b1;
      if (n == 10) chk("timeout_busy_before", 32'(busy), 32'h1);
      if (frame_err) got = 1'b1;
    end
    chk("timeout_latency", 32'(n), 32'(TIMEOUT_CYCLES + 6));
    chk("timeout_busy_after", 32'(busy), 32'h0);
    ps2_data = 1'b1;
    repeat (50) @(negedge clk);

    // Short low glitches with data low: a leak would start a frame.
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch1_busy", 32'(busy), 32'h0);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch3_busy", 32'(busy), 32'h0);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);

    // F0 has four ones, so its parity bit is 1.
`ifdef PS2_BREAK_TRACK_EN
    push_exp(S_CODE, 8'h1C, 1'b1);
`else
    push_exp(S_CODE, 8'hF0, 1'b0);
    push_exp(S_CODE, 8'h1C, 1'b0);
`endif
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Reset while the receiver is partway through the data bits.
    for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
    @(negedge clk);
    ps2_data = bits[5];
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("midreset_scan_code", 32'(scan_code), 32'h00);
    chk("midreset_busy",      32'(busy),      32'h0);
    chk("midreset_strobes",   32'({code_valid, is_break, parity_err, frame_err}), 32'h0);
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    push_exp(S_CODE, 8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    repeat (300) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
